// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: N-port memory arbiter that merges several requesters onto
// the single memory_* bus of the core.
//
// Each requester issues a one-cycle request pulse. The pulse is captured into
// a per-port pending slot, so no request is lost while the bus is busy. One
// transaction is in flight at a time. The winner is chosen either by fixed
// priority (lowest index wins) or by round-robin, starting after the last
// grant.
//
// Ports:
//   rst            async active-high reset
//   clk            clock, all state on the rising edge
//   port_valid     one-cycle request pulse per port
//   port_instr     request is an instruction fetch
//   port_addr      packed addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   port_wdata     packed write data, same slicing
//   port_wstrb     packed byte strobes (all zero = read)
//   port_rdata     memory_rdata broadcast to every port (unregistered)
//   port_ready     one-hot completion pulse for the owning port
//   memory_valid   request on the bus, held until memory_ready
//   memory_instr   fetch flag of the granted request
//   memory_addr    address of the granted request
//   memory_wdata   write data of the granted request
//   memory_wstrb   strobes of the granted request
//   memory_rdata   read data, valid with memory_ready
//   memory_ready   completes the current transaction
module mem_arbiter_n #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE   = 0,
  localparam int GW = $clog2(NUM_PORTS),
  localparam int SW = DATA_WIDTH / 8
) (
  input  logic                         rst,
  input  logic                         clk,
  input  logic [NUM_PORTS-1:0]         port_valid,
  input  logic [NUM_PORTS-1:0]         port_instr,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata,
  input  logic [NUM_PORTS*SW-1:0]      port_wstrb,
  output logic [DATA_WIDTH-1:0]        port_rdata,
  output logic [NUM_PORTS-1:0]         port_ready,
  output logic                         memory_valid,
  output logic                         memory_instr,
  output logic [ADDR_WIDTH-1:0]        memory_addr,
  output logic [DATA_WIDTH-1:0]        memory_wdata,
  output logic [SW-1:0]                memory_wstrb,
  input  logic [DATA_WIDTH-1:0]        memory_rdata,
  input  logic                         memory_ready
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state, state_next;

  // Pending slots, one per port
  logic [NUM_PORTS-1:0]  pend_v;
  logic [NUM_PORTS-1:0]  slot_instr;
  logic [ADDR_WIDTH-1:0] slot_addr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] slot_wdata [NUM_PORTS];
  logic [SW-1:0]         slot_wstrb [NUM_PORTS];

  // Per-port views of the packed input vectors
  logic [ADDR_WIDTH-1:0] in_addr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] in_wdata [NUM_PORTS];
  logic [SW-1:0]         in_wstrb [NUM_PORTS];

  logic [NUM_PORTS-1:0]  cand;
  logic                  arb_open;
  logic                  issue;
  logic [GW-1:0]         win_idx;
  logic [GW-1:0]         grant;
  logic [GW-1:0]         last_grant;

  logic                  win_instr;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic [SW-1:0]         win_wstrb;

  // Split the packed port buses into per-port arrays
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      in_addr[i]  = port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      in_wdata[i] = port_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      in_wstrb[i] = port_wstrb[i*SW +: SW];
    end
  end

  // Candidate set and whether a new grant may be made at this edge
  always_comb begin
    cand = pend_v | port_valid;
    case (state)
      IDLE:    arb_open = 1'b1;
      BUSY:    arb_open = memory_ready;
      default: arb_open = 1'b0;
    endcase
    issue = arb_open & (|cand);
  end

  // Winner selection. The scan runs from the last search position down to
  // the first, so the earliest position in search order is assigned last
  // and wins. Mode 1 starts the search just after the last grant, with wrap.
  always_comb begin
    win_idx = {GW{1'b0}};
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      win_idx = cand[(ARB_MODE == 1) ? GW'((int'(last_grant) + 1 + k) % NUM_PORTS) : GW'(k)]
              ? ((ARB_MODE == 1) ? GW'((int'(last_grant) + 1 + k) % NUM_PORTS) : GW'(k))
              : win_idx;
    end
  end

  // Winner fields. A same-cycle pulse takes precedence over the slot contents.
  always_comb begin
    if (port_valid[win_idx]) begin
      win_instr = port_instr[win_idx];
      win_addr  = in_addr[win_idx];
      win_wdata = in_wdata[win_idx];
      win_wstrb = in_wstrb[win_idx];
    end else begin
      win_instr = slot_instr[win_idx];
      win_addr  = slot_addr[win_idx];
      win_wdata = slot_wdata[win_idx];
      win_wstrb = slot_wstrb[win_idx];
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state. Completion with more work queued stays in BUSY.
  always_comb begin
    case (state)
      IDLE:    state_next = issue ? BUSY : IDLE;
      BUSY:    state_next = (!memory_ready || issue) ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: bus valid and the completion pulse to the owning port
  always_comb begin
    port_rdata = memory_rdata;
    case (state)
      IDLE: begin
        memory_valid = 1'b0;
        port_ready   = {NUM_PORTS{1'b0}};
      end
      BUSY: begin
        memory_valid = 1'b1;
        port_ready   = memory_ready ? ({{(NUM_PORTS-1){1'b0}}, 1'b1} << grant)
                                    : {NUM_PORTS{1'b0}};
      end
      default: begin
        memory_valid = 1'b0;
        port_ready   = {NUM_PORTS{1'b0}};
      end
    endcase
  end

  // Bus request registers and grant tracking. These load only when a
  // grant is made, so they stay stable across a ready stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memory_instr <= 1'b0;
      memory_addr  <= {ADDR_WIDTH{1'b0}};
      memory_wdata <= {DATA_WIDTH{1'b0}};
      memory_wstrb <= {SW{1'b0}};
      grant        <= {GW{1'b0}};
      last_grant   <= GW'(NUM_PORTS - 1);
    end else if (issue) begin
      memory_instr <= win_instr;
      memory_addr  <= win_addr;
      memory_wdata <= win_wdata;
      memory_wstrb <= win_wstrb;
      grant        <= win_idx;
      last_grant   <= win_idx;
    end
  end

  // Pending slots. The winner's slot is consumed. Any other pulse fills or
  // overwrites its slot, including a pulse from the port currently in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v     <= {NUM_PORTS{1'b0}};
      slot_instr <= {NUM_PORTS{1'b0}};
      for (int i = 0; i < NUM_PORTS; i++) begin
        slot_addr[i]  <= {ADDR_WIDTH{1'b0}};
        slot_wdata[i] <= {DATA_WIDTH{1'b0}};
        slot_wstrb[i] <= {SW{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (issue && (win_idx == GW'(i))) begin
          pend_v[i] <= 1'b0;
        end else if (port_valid[i]) begin
          pend_v[i]     <= 1'b1;
          slot_instr[i] <= port_instr[i];
          slot_addr[i]  <= in_addr[i];
          slot_wdata[i] <= in_wdata[i];
          slot_wstrb[i] <= in_wstrb[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Bench for mem_arbiter_n. Two instances run side by side: instance 0 has
// 2 ports with fixed priority, and instance 1 has 4 ports with round-robin.
// A transaction-level model tracks each instance and is compared on every
// negative clock edge. Directed checks with literal values pin the model.
module tb_mem_arbiter_n;

  typedef struct packed {
    logic        v;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Stimulus, indexed [instance][port]
  logic        in_valid  [2][4];
  req_t        in_req    [2][4];
  logic        in_mready [2];
  logic [31:0] in_mrdata [2];

  // Instance 0 ports
  logic [1:0]  a_valid, a_instr, a_pready;
  logic [63:0] a_addr, a_wdata;
  logic [7:0]  a_wstrb;
  logic [31:0] a_prdata, a_maddr, a_mwdata;
  logic        a_mvalid, a_minstr;
  logic [3:0]  a_mwstrb;

  // Instance 1 ports
  logic [3:0]   b_valid, b_instr, b_pready;
  logic [127:0] b_addr, b_wdata;
  logic [15:0]  b_wstrb;
  logic [31:0]  b_prdata, b_maddr, b_mwdata;
  logic         b_mvalid, b_minstr;
  logic [3:0]   b_mwstrb;

  mem_arbiter_n #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0)) dut0 (
    .rst(rst), .clk(clk),
    .port_valid(a_valid), .port_instr(a_instr), .port_addr(a_addr),
    .port_wdata(a_wdata), .port_wstrb(a_wstrb),
    .port_rdata(a_prdata), .port_ready(a_pready),
    .memory_valid(a_mvalid), .memory_instr(a_minstr), .memory_addr(a_maddr),
    .memory_wdata(a_mwdata), .memory_wstrb(a_mwstrb),
    .memory_rdata(in_mrdata[0]), .memory_ready(in_mready[0])
  );

  mem_arbiter_n #(.NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(1)) dut1 (
    .rst(rst), .clk(clk),
    .port_valid(b_valid), .port_instr(b_instr), .port_addr(b_addr),
    .port_wdata(b_wdata), .port_wstrb(b_wstrb),
    .port_rdata(b_prdata), .port_ready(b_pready),
    .memory_valid(b_mvalid), .memory_instr(b_minstr), .memory_addr(b_maddr),
    .memory_wdata(b_mwdata), .memory_wstrb(b_mwstrb),
    .memory_rdata(in_mrdata[1]), .memory_ready(in_mready[1])
  );

  // Pack the per-port stimulus into the DUT buses
  always_comb begin
    a_valid = '0; a_instr = '0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
    b_valid = '0; b_instr = '0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
    for (int p = 0; p < 2; p++) begin
      a_valid[p]          = in_valid[0][p];
      a_instr[p]          = in_req[0][p].instr;
      a_addr[p*32 +: 32]  = in_req[0][p].addr;
      a_wdata[p*32 +: 32] = in_req[0][p].wdata;
      a_wstrb[p*4 +: 4]   = in_req[0][p].wstrb;
    end
    for (int p = 0; p < 4; p++) begin
      b_valid[p]          = in_valid[1][p];
      b_instr[p]          = in_req[1][p].instr;
      b_addr[p*32 +: 32]  = in_req[1][p].addr;
      b_wdata[p*32 +: 32] = in_req[1][p].wdata;
      b_wstrb[p*4 +: 4]   = in_req[1][p].wstrb;
    end
  end

  // Uniform views of both instances' outputs
  logic        o_valid [2];
  logic        o_instr [2];
  logic [3:0]  o_ready [2];
  logic [31:0] o_addr  [2];
  logic [31:0] o_wdata [2];
  logic [31:0] o_rdata [2];
  logic [3:0]  o_wstrb [2];
  always_comb begin
    o_valid[0] = a_mvalid; o_instr[0] = a_minstr; o_ready[0] = {2'b00, a_pready};
    o_addr[0]  = a_maddr;  o_wdata[0] = a_mwdata; o_rdata[0] = a_prdata; o_wstrb[0] = a_mwstrb;
    o_valid[1] = b_mvalid; o_instr[1] = b_minstr; o_ready[1] = b_pready;
    o_addr[1]  = b_maddr;  o_wdata[1] = b_mwdata; o_rdata[1] = b_prdata; o_wstrb[1] = b_mwstrb;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: one request slot per port plus the bus owner
  int   np   [2] = '{2, 4};
  int   mode [2] = '{0, 1};
  req_t pend [2][4];
  req_t cur  [2];
  bit   busy [2];
  int   owner[2];
  int   last [2];
  int   grant_log[$];

  task automatic model_reset(input int m);
    busy[m] = 1'b0;
    owner[m] = 0;
    last[m] = np[m] - 1;
    cur[m] = '0;
    for (int p = 0; p < 4; p++) pend[m][p] = '0;
  endtask

  task automatic model_advance(input int m);
    int w;
    int p;
    bit issued;
    w = -1;
    issued = 1'b0;
    if (!busy[m] || in_mready[m]) begin
      for (int k = 0; k < np[m]; k++) begin
        p = (mode[m] == 1) ? (last[m] + 1 + k) % np[m] : k;
        if (w < 0 && (pend[m][p].v || in_valid[m][p])) w = p;
      end
      if (w >= 0) begin
        cur[m]      = in_valid[m][w] ? in_req[m][w] : pend[m][w];
        busy[m]     = 1'b1;
        owner[m]    = w;
        last[m]     = w;
        pend[m][w].v = 1'b0;
        issued      = 1'b1;
      end else begin
        busy[m] = 1'b0;
      end
    end
    for (int q = 0; q < np[m]; q++) begin
      if (in_valid[m][q] && !(issued && w == q)) begin
        pend[m][q]   = in_req[m][q];
        pend[m][q].v = 1'b1;
      end
    end
  endtask

  // Per-cycle comparison of both instances against the model
  logic [3:0] exp_ready;
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) model_reset(m);
      exp_ready = (busy[m] && in_mready[m]) ? 4'(1 << owner[m]) : 4'b0000;
      chk($sformatf("u%0d memory_valid", m), {63'd0, o_valid[m]}, {63'd0, busy[m]});
      chk($sformatf("u%0d port_ready", m), {60'd0, o_ready[m]}, {60'd0, exp_ready});
      if (busy[m]) begin
        chk($sformatf("u%0d memory_addr", m),  {32'd0, o_addr[m]},  {32'd0, cur[m].addr});
        chk($sformatf("u%0d memory_wdata", m), {32'd0, o_wdata[m]}, {32'd0, cur[m].wdata});
        chk($sformatf("u%0d memory_wstrb", m), {60'd0, o_wstrb[m]}, {60'd0, cur[m].wstrb});
        chk($sformatf("u%0d memory_instr", m), {63'd0, o_instr[m]}, {63'd0, cur[m].instr});
      end
      if (exp_ready != 4'b0000) begin
        chk($sformatf("u%0d port_rdata", m), {32'd0, o_rdata[m]}, {32'd0, in_mrdata[m]});
      end
      if (m == 1) begin
        for (int p = 0; p < 4; p++) if (o_ready[1][p]) grant_log.push_back(p);
      end
      if (!rst) model_advance(m);
    end
  end

  // Advance one cycle; inputs are changed 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      in_mready[m] = 1'b0;
      for (int p = 0; p < 4; p++) in_valid[m][p] = 1'b0;
    end
  endtask

  task automatic pulse(input int m, input int p, input logic instr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    in_valid[m][p] = 1'b1;
    in_req[m][p]   = '{v: 1'b1, instr: instr, addr: addr, wdata: wdata, wstrb: wstrb};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      in_mready[m] = 1'b0;
      in_mrdata[m] = 32'h0;
      for (int p = 0; p < 4; p++) begin
        in_valid[m][p] = 1'b0;
        in_req[m][p]   = '0;
      end
    end
    rst = 1'b1;
    @(negedge clk);
    chk("reset memory_valid", {63'd0, a_mvalid}, 64'd0);
    chk("reset memory_addr", {32'd0, a_maddr}, 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // memory_ready while idle is ignored
    in_mready[0] = 1'b1;
    @(negedge clk);
    chk("idle ready ignored", {60'd0, o_ready[0]}, 64'd0);
    tick();

    // Single read from port 1, ready three cycles after the pulse
    pulse(0, 1, 1'b0, 32'h100, 32'h0, 4'h0);
    tick();
    @(negedge clk);
    chk("t1 valid cycle1", {63'd0, a_mvalid}, 64'd1);
    tick(); tick();
    in_mready[0] = 1'b1;
    in_mrdata[0] = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1 port_ready", {62'd0, a_pready}, 64'h2);
    chk("t1 port_rdata", {32'd0, a_prdata}, 64'hDEADBEEF);
    chk("t1 memory_addr", {32'd0, a_maddr}, 64'h100);
    tick();
    @(negedge clk);
    chk("t1 idle after", {63'd0, a_mvalid}, 64'd0);
    tick();

    // Both ports in the same cycle: port 0 first, then back-to-back port 1
    pulse(0, 0, 1'b1, 32'h10, 32'h0, 4'h0);
    pulse(0, 1, 1'b0, 32'h20, 32'h0, 4'h0);
    tick();
    @(negedge clk);
    chk("t2 first addr", {32'd0, a_maddr}, 64'h10);
    chk("t2 first instr", {63'd0, a_minstr}, 64'd1);
    tick();
    in_mready[0] = 1'b1;
    @(negedge clk);
    chk("t2 ready port0", {62'd0, a_pready}, 64'h1);
    tick();
    in_mready[0] = 1'b1;
    @(negedge clk);
    chk("t2 valid held", {63'd0, a_mvalid}, 64'd1);
    chk("t2 second addr", {32'd0, a_maddr}, 64'h20);
    chk("t2 ready port1", {62'd0, a_pready}, 64'h2);
    tick();

    // Write stable across a five-cycle ready stall
    pulse(0, 0, 1'b0, 32'h2000, 32'h1234ABCD, 4'b0011);
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("t4 addr stall%0d", c), {32'd0, a_maddr}, 64'h2000);
      chk($sformatf("t4 wdata stall%0d", c), {32'd0, a_mwdata}, 64'h1234ABCD);
      chk($sformatf("t4 wstrb stall%0d", c), {60'd0, a_mwstrb}, 64'h3);
      tick();
    end
    in_mready[0] = 1'b1;
    @(negedge clk);
    chk("t4 ready", {62'd0, a_pready}, 64'h1);
    tick();

    // Port 0 re-pulses in its own completion cycle
    pulse(0, 0, 1'b0, 32'h40, 32'h0, 4'h0);
    tick();
    in_mready[0] = 1'b1;
    pulse(0, 0, 1'b0, 32'h44, 32'h0, 4'h0);
    tick();
    in_mready[0] = 1'b1;
    @(negedge clk);
    chk("t6 reissue valid", {63'd0, a_mvalid}, 64'd1);
    chk("t6 reissue addr", {32'd0, a_maddr}, 64'h44);
    tick();

    // Reset while busy with two pending requests
    pulse(0, 0, 1'b0, 32'h80, 32'h0, 4'h0);
    tick();
    pulse(0, 1, 1'b0, 32'h90, 32'h0, 4'h0);
    pulse(0, 0, 1'b0, 32'h84, 32'h0, 4'h0);
    tick();
    rst = 1'b1;
    in_mready[0] = 1'b1;
    @(negedge clk);
    chk("t5 valid in reset", {63'd0, a_mvalid}, 64'd0);
    chk("t5 no ready", {62'd0, a_pready}, 64'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("t5 idle after reset %0d", c), {63'd0, a_mvalid}, 64'd0);
      tick();
    end
    pulse(0, 1, 1'b0, 32'hA0, 32'h0, 4'h0);
    tick();
    in_mready[0] = 1'b1;
    in_mrdata[0] = 32'h5555AAAA;
    @(negedge clk);
    chk("t5 new addr", {32'd0, a_maddr}, 64'hA0);
    chk("t5 new ready", {62'd0, a_pready}, 64'h2);
    tick();

    // Round-robin, 4 ports, all re-requesting every cycle
    for (int p = 0; p < 4; p++) pulse(1, p, 1'b0, 32'h1000 + 32'(p * 16), 32'(p), 4'hF);
    tick();
    for (int c = 0; c < 8; c++) begin
      for (int p = 0; p < 4; p++)
        pulse(1, p, p[0], 32'h1000 + 32'(p * 16 + c + 1), 32'(c), 4'(p));
      in_mready[1] = 1'b1;
      in_mrdata[1] = 32'hC0DE0000 + 32'(c);
      tick();
    end
    for (int c = 0; c < 6; c++) begin
      in_mready[1] = 1'b1;
      tick();
    end
    chk("t3 grant count", 64'(grant_log.size() >= 8), 64'd1);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      chk($sformatf("t3 grant[%0d]", i), 64'(grant_log[i]), 64'(i % 4));

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
